uart_tx_sched: RTL
==================

// Module: uart_tx_sched
// PURPOSE
//  Shares one UART transmit line between NUM_REQ byte requesters. Round-robin arbiter picks a requester,
//  latches its byte, and sequences start/data/[parity]/stop bits onto txd at a programmable bit period.
//  Sits between subsystem masters (console, debug, DMA) and the UART pad (GPIO pin 16 path).
// PARAMETERS
//  NUM_REQ   4    number of requesters (>=2)
//  DIV_W     16   width of bit-period divisor
//  ID_W      2    grant id width, = clog2(NUM_REQ)
// PORTS
//  clk        in   1             system clock
//  rst        in   1             asynchronous reset, active-high
//  tx_en      in   1             enable arbitration of new frames
//  baud_div   in   DIV_W         bit period = baud_div+1 clk cycles
//  req_valid  in   NUM_REQ       per-requester byte valid
//  req_data   in   NUM_REQ*8     per-requester byte, requester i at [8i+7:8i]
//  req_ready  out  NUM_REQ       one-hot accept, combinational in IDLE
//  txd        out  1             serial line, idle high
//  busy       out  1             frame in progress (state != IDLE)
//  grant_id   out  ID_W          id of requester owning current/last frame
//  frame_done out  1             one-cycle pulse at end of stop bit
// BEHAVIOUR
//  Reset: txd=1, busy=0, grant_id=0, frame_done=0, req_ready=0, rr pointer=0, state=IDLE.
//  Reset mid-frame: txd returns to 1 asynchronously; partial frame abandoned, nothing retransmitted.
//  FSM: IDLE -> START -> DATA(x8, LSB first) -> [PARITY] -> STOP -> IDLE.
//  IDLE: if tx_en & |req_valid, grant first valid requester at/after rr pointer (wrap NUM_REQ-1 -> 0);
//   req_ready[g]=1 that cycle only; byte, g, baud_div latched; rr pointer <= g+1 (mod NUM_REQ).
//  Handshake: transfer on req_valid[i]&req_ready[i]; ready never asserted outside IDLE or with tx_en=0.
//  Latency: accept at cycle N -> txd=0 (start) from cycle N+1.
//  Bit timer: counts 0..latched baud_div; each bit holds exactly baud_div+1 cycles; baud_div=0 -> 1 cycle/bit.
//  baud_div changes mid-frame have no effect until next accept.
//  STOP: txd=1; on its last cycle frame_done=1 and state -> IDLE; next frame may accept in that IDLE cycle,
//   so back-to-back frames have exactly 1 extra idle-high cycle.
//  tx_en deasserted mid-frame: current frame completes; no new grant until tx_en=1.
//  Requester dropping req_valid while not granted: no effect, no state held for it.
//  busy=1 from START first cycle through STOP last cycle.
// CONFIGURATION
//  UX607_UART_PARITY_EN defined: PARITY state inserted after DATA, txd = even parity (XOR of 8 data bits);
//   frame = 11 bits, 11*(baud_div+1) cycles.
//  Not defined: DATA -> STOP directly; frame = 10 bits, 10*(baud_div+1) cycles.
// STRUCTURE
//  ux607_uart_defines.v: FSM state encodings (IDLE/START/DATA/PARITY/STOP), frame length constants,
//   UART_IDLE_LVL=1'b1.
//  Sub-module uart_rr_arbiter: NUM_REQ request vector + pointer -> one-hot grant + encoded id.
//  Top holds FSM, bit timer, 3-bit data index, shift register, parity accumulator.
// TESTING
//  T1 reset: assert rst mid-DATA -> txd=1, busy=0, req_ready=0 same cycle; post-reset first grant is req0.
//  T2 single frame, baud_div=3, req1 sends 8'hA5 -> txd 0,1,0,1,0,0,1,0,1,[0],1 each 4 cycles; frame_done once.
//  T3 all 4 requesters valid continuously, 0x10..0x13 -> grants 0,1,2,3,0 order; 1 idle cycle between frames.
//  T4 baud_div=0 -> each bit 1 cycle; frame 11 (parity) / 10 (no parity) cycles + 1 idle.
//  T5 tx_en dropped during DATA -> frame completes, no further req_ready until tx_en=1.
//  T6 8'h07 with UX607_UART_PARITY_EN -> parity bit=1; 8'h03 -> parity bit=0; receiver model compares all 256 bytes.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx_sched transmit scheduler.
// Frame length follows UX607_UART_PARITY_EN (even parity bit after the data bits).
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS        = 8;
  localparam int   FRAME_BITS_PAR   = 11;
  localparam int   FRAME_BITS_NOPAR = 10;
  localparam logic UART_IDLE_LVL    = 1'b1;

`ifdef UX607_UART_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
  localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping at NUM_REQ-1.
// Produces a one-hot grant and the matching encoded id.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id
);

  logic          found;
  logic [ID_W:0] j;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One spare bit so ptr+k can exceed NUM_REQ-1 before wrapping back.
      j = {1'b0, ptr} + (ID_W+1)'(k);
      if (j >= (ID_W+1)'(NUM_REQ)) begin
        j = j - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req[j[ID_W-1:0]]) begin
        found             = 1'b1;
        gnt[j[ID_W-1:0]]  = 1'b1;
        id                = j[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART TX line between NUM_REQ byte requesters using round-robin arbitration.
// Define UX607_UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_W   = 16,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 txd,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 frame_done
);

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic             txd_q, txd_d;
  logic             live_q, live_d;
`ifdef UX607_UART_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic [7:0]         req_byte [NUM_REQ];
  logic               accept;
  logic               bit_end;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  // live_q keeps req_ready low while reset is held and for the first cycle after.
  assign accept    = (state_q == ST_IDLE) && tx_en && live_q && (|req_valid);
  assign req_ready = accept ? arb_gnt : '0;
  assign bit_end   = (timer_q == div_q);
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = gid_q;
  assign txd       = txd_q;
  assign live_d    = 1'b1;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    rr_d       = rr_q;
    gid_d      = gid_q;
    txd_d      = txd_q;
    frame_done = 1'b0;
`ifdef UX607_UART_PARITY_EN
    par_d      = par_q;
`endif
    if (state_q != ST_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          div_d   = baud_div;
          timer_d = '0;
          idx_d   = '0;
          shreg_d = req_byte[arb_id];
          gid_d   = arb_id;
          rr_d    = (arb_id == ID_W'(NUM_REQ-1)) ? '0 : arb_id + 1'b1;
          txd_d   = 1'b0;
`ifdef UX607_UART_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          txd_d   = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 1'b1;
`ifdef UX607_UART_PARITY_EN
          par_d   = par_q ^ shreg_q[0];
`endif
          if (idx_q == 3'(DATA_BITS-1)) begin
`ifdef UX607_UART_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = par_q ^ shreg_q[0];
`else
            state_d = ST_STOP;
            txd_d   = UART_IDLE_LVL;
`endif
          end else begin
            txd_d = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          txd_d   = UART_IDLE_LVL;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
          txd_d      = UART_IDLE_LVL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = UART_IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      rr_q    <= '0;
      gid_q   <= '0;
      txd_q   <= UART_IDLE_LVL;
      live_q  <= 1'b0;
`ifdef UX607_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      txd_q   <= txd_d;
      live_q  <= live_d;
`ifdef UX607_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
